// File: rtl/falu_issue_ctrl_if.sv
// falu_issue_ctrl_if
//   Bundles the issue handshake, ALU control and writeback signals of the
//   FP ALU sequencer.
//   master : issue stage / ALU / register-file side (drives req_*, flush,
//            wb_ready; observes everything else)
//   slave  : the sequencer itself (falu_issue_ctrl)
interface falu_issue_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic [4:0] req_rd;
  logic       flush;
  logic [2:0] falu_ctrl;
  logic       falu_start;
  logic       falu_capture;
  logic       wb_valid;
  logic       wb_ready;
  logic [4:0] wb_rd;
  logic       busy;
  logic [4:0] pend_rd;
  logic       illegal;

  modport master (
    output req_valid, req_op, req_rd, flush, wb_ready,
    input  req_ready, falu_ctrl, falu_start, falu_capture,
           wb_valid, wb_rd, busy, pend_rd, illegal
  );

  modport slave (
    input  req_valid, req_op, req_rd, flush, wb_ready,
    output req_ready, falu_ctrl, falu_start, falu_capture,
           wb_valid, wb_rd, busy, pend_rd, illegal
  );
endinterface

// File: rtl/falu_issue_ctrl.sv
// falu_issue_ctrl
//   Sequencer in front of the FP ALU. Accepts one op at a time over a
//   valid/ready handshake, drives the ALU op select / start / capture
//   strobes, counts the unit's fixed latency and then holds a writeback
//   request until the register-file port acknowledges it.
// Ports:
//   CLK  - clock, rising edge
//   rst  - synchronous active-high reset (priority over flush)
//   bus  - falu_issue_ctrl_if.slave: req_valid/req_ready/req_op/req_rd,
//          flush, falu_ctrl/falu_start/falu_capture, wb_valid/wb_ready/wb_rd,
//          busy, pend_rd, illegal
// Configuration:
//   FALU_DIV_EN - when defined, op 3'b010 (divide) is legal with DIV_LAT;
//                 otherwise it is rejected as illegal.
// All outputs are registered except req_ready (state + flush).
module falu_issue_ctrl #(
  parameter int unsigned ADD_LAT = 1,
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned DIV_LAT = 16,
  parameter int unsigned CMP_LAT = 1,
  parameter int unsigned CVT_LAT = 1,
  parameter int unsigned CNT_W   = 5
) (
  input logic              CLK,
  input logic              rst,
  falu_issue_ctrl_if.slave bus
);

  // Every latency must fit the counter as LAT-1.
  if ((ADD_LAT < 1) || (ADD_LAT > (1 << CNT_W)) ||
      (MUL_LAT < 1) || (MUL_LAT > (1 << CNT_W)) ||
      (DIV_LAT < 1) || (DIV_LAT > (1 << CNT_W)) ||
      (CMP_LAT < 1) || (CMP_LAT > (1 << CNT_W)) ||
      (CVT_LAT < 1) || (CVT_LAT > (1 << CNT_W))) begin : g_bad_lat
    $error("falu_issue_ctrl: latency parameter out of range 1..2**CNT_W");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_WB
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         ctrl_q, ctrl_d;
  logic [4:0]         rd_q, rd_d;
  logic               start_q, start_d;
  logic               capture_q, capture_d;
  logic               wb_valid_q, wb_valid_d;
  logic               busy_q, busy_d;
  logic               illegal_q, illegal_d;

  logic               req_ready_c;
  logic               op_legal;
  logic [CNT_W-1:0]   lat_m1;

  // Opcode decode: legality and counter load value (LAT-1).
  always_comb begin
    op_legal = 1'b1;
    lat_m1   = '0;
    unique case (bus.req_op)
      3'b000:  lat_m1 = CNT_W'(ADD_LAT - 1);
      3'b001:  lat_m1 = CNT_W'(MUL_LAT - 1);
`ifdef FALU_DIV_EN
      3'b010:  lat_m1 = CNT_W'(DIV_LAT - 1);
`endif
      3'b011:  lat_m1 = CNT_W'(CMP_LAT - 1);
      3'b100:  lat_m1 = CNT_W'(CVT_LAT - 1);
      default: op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ctrl_d     = ctrl_q;
    rd_d       = rd_q;
    start_d    = 1'b0;
    capture_d  = 1'b0;
    wb_valid_d = 1'b0;
    illegal_d  = 1'b0;

    req_ready_c = (state_q == ST_IDLE) && !bus.flush;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && req_ready_c) begin
          if (op_legal) begin
            state_d   = ST_EXEC;
            ctrl_d    = bus.req_op;
            rd_d      = bus.req_rd;
            cnt_d     = lat_m1;
            start_d   = 1'b1;
            // Single-cycle units capture in the same cycle as start.
            capture_d = (lat_m1 == '0);
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d    = ST_WB;
          wb_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
          // Registered capture: raise it for the cycle in which cnt reaches 0.
          capture_d = (cnt_q == CNT_W'(1));
        end
      end
      ST_WB: begin
        if (bus.flush || bus.wb_ready) begin
          state_d = ST_IDLE;
        end else begin
          wb_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      ctrl_q     <= '0;
      rd_q       <= '0;
      start_q    <= 1'b0;
      capture_q  <= 1'b0;
      wb_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ctrl_q     <= ctrl_d;
      rd_q       <= rd_d;
      start_q    <= start_d;
      capture_q  <= capture_d;
      wb_valid_q <= wb_valid_d;
      busy_q     <= busy_d;
      illegal_q  <= illegal_d;
    end
  end

  assign bus.req_ready    = req_ready_c;
  assign bus.falu_ctrl    = ctrl_q;
  assign bus.falu_start   = start_q;
  assign bus.falu_capture = capture_q;
  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_rd        = rd_q;
  assign bus.pend_rd      = rd_q;
  assign bus.busy         = busy_q;
  assign bus.illegal      = illegal_q;

endmodule

// File: doc/falu_issue_ctrl.md
# falu_issue_ctrl

Sequencer in front of the floating-point ALU. It accepts one FP operation at a time from the decode/issue stage over a valid/ready handshake and drives the ALU's operation select, start strobe and result-capture strobe. It counts each unit's fixed latency, then holds a writeback request until the register-file write port acknowledges it. It also exposes busy and pending-destination signals so the pipeline can stall and detect FP RAW hazards.

## Interface
- ADD_LAT, 1, cycles for add/sub (op 3'b000)
- MUL_LAT, 2, cycles for multiply (op 3'b001)
- DIV_LAT, 16, cycles for divide (op 3'b010)
- CMP_LAT, 1, cycles for compare (op 3'b011)
- CVT_LAT, 1, cycles for convert (op 3'b100)
- CNT_W, 5, latency counter width; every *_LAT must be in 1..2^CNT_W
- CLK  in  1  clock; single clock domain, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  issue request present
- req_ready  out  1  controller can accept
- req_op  in  3  operation code (FALU_ctrl encoding above)
- req_rd  in  5  FP destination register
- flush  in  1  pipeline flush; aborts any in-flight op
- falu_ctrl  out  3  operation select to the ALU
- falu_start  out  1  one-cycle start strobe
- falu_capture  out  1  ALU result-register load strobe
- wb_valid  out  1  result ready for writeback
- wb_ready  in  1  writeback port accepts
- wb_rd  out  5  destination for writeback
- busy  out  1  op in EXEC or WB
- pend_rd  out  5  destination of in-flight op; valid when busy=1
- illegal  out  1  one-cycle pulse on rejected opcode

## Operation
- States: IDLE, EXEC, WB.
- IDLE:
  - req_ready = !flush.
  - Accept = req_valid & req_ready.
  - Legal accept: latch op into falu_ctrl and rd into wb_rd/pend_rd; load cnt = LAT(op)-1; go to EXEC.
  - Illegal accept (opcodes 101/110/111, plus 010 when divide is compiled out): illegal=1 next cycle; stay IDLE; no writeback.
- EXEC:
  - falu_start=1 on the first EXEC cycle only.
  - cnt decrements by 1 each cycle while cnt≠0.
  - falu_capture=1 in the cycle where cnt==0; the next state is WB.
- WB:
  - wb_valid=1.
  - On wb_ready=1 the next state is IDLE.
  - wb_valid and wb_rd stay stable until the handshake completes.
- busy = (state≠IDLE). req_ready=0 whenever busy.
- flush:
  - In EXEC or WB: next state is IDLE; no wb_valid follows.
  - Aborting mid-EXEC suppresses the pending falu_capture.
  - A flush coinciding with wb_ready in WB still goes to IDLE; the write is treated as completed by the consumer.
- The latency counter saturates at 0 and never wraps.
- falu_ctrl holds its last value in IDLE.
- Reset values: state IDLE, falu_ctrl 3'b000, cnt 0, wb_rd/pend_rd 0, all strobes and valids 0. req_ready=1 the cycle after reset releases.
- Reset mid-operation discards the op with no wb_valid; rst has priority over flush.

## Timing
- Accept at edge T:
  - falu_start high in cycle T+1.
  - falu_capture high in cycle T+LAT.
  - wb_valid first high in cycle T+LAT+1.
- Minimum issue interval: LAT+2 cycles (one IDLE cycle between ops).
- All outputs except req_ready are registered. req_ready is combinational from state and flush.
- With wb_ready tied high, WB lasts exactly one cycle.

## Configuration
- FALU_DIV_EN defined: op 3'b010 is legal and uses DIV_LAT.
- FALU_DIV_EN undefined: op 3'b010 is illegal (illegal pulse, no EXEC), and the DIV_LAT counter-load path is removed.

## Test plan
- Add, wb_ready=1: accept op 000 rd=7 at T -> falu_start at T+1, falu_capture at T+1, wb_valid with wb_rd=7 at T+2, req_ready=1 at T+3.
- Multiply with backpressure: op 001 rd=3, wb_ready=0 for 4 cycles -> wb_valid from T+3 held 5 cycles with wb_rd=3; busy=1 and pend_rd=3 throughout; req_ready=0 until the handshake completes.
- Divide with FALU_DIV_EN defined: op 010 -> capture at T+16, wb_valid at T+17. Without the macro: illegal=1 at T+1, busy never asserts.
- Illegal ops: op 111 -> illegal pulse one cycle, req_ready stays 1, no falu_start.
- Flush at T+5 during a divide -> IDLE at T+6, no falu_capture and no wb_valid. Request with flush=1 in IDLE -> not accepted.
- rst asserted mid-EXEC of a multiply -> all outputs at reset values next cycle; a following add completes with normal latency.
